// File: rtl/ram_arb_pkg.sv
// Shared defaults, requester-index type and the address range check for ram_port_arbiter.
package ram_arb_pkg;

  localparam int unsigned ARB_DATA_W = 8;
  localparam int unsigned ARB_ADDR_W = 6;
  localparam int unsigned ARB_DEPTH  = 32;

  typedef logic req_idx_t;

  function automatic logic in_range(input logic [31:0] a, input int unsigned depth = ARB_DEPTH);
    return a < depth;
  endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Grant selection for two requesters.
// RAM_ARB_RR_EN defined: round-robin on the last-granted pointer; undefined: requester 0 has fixed priority.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef RAM_ARB_RR_EN
  input  req_idx_t   lg_i,
`endif
  output logic [1:0] gnt_o,
  output req_idx_t   winner_o
);

  always_comb begin
    // NOTE: outputs get defaults before the case so every path assigns them and no latch is inferred.
    winner_o = 1'b0;
    gnt_o    = 2'b00;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
`ifdef RAM_ARB_RR_EN
      2'b11:   winner_o = ~lg_i;
`else
      2'b11:   winner_o = 1'b0;
`endif
      default: winner_o = 1'b0;
    endcase
    if (|req_i) gnt_o = 2'b01 << winner_o;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a single-port RAM: port mux, range check and registered read return.
// Build option RAM_ARB_RR_EN selects round-robin instead of fixed priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DEPTH  = ARB_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  logic [1:0]        gnt_raw;
  req_idx_t          winner;
  logic              grant_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              win_in_range;

  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;

`ifdef RAM_ARB_RR_EN
  req_idx_t lg_q, lg_d;
`endif

  ram_arb_grant u_grant (
    .req_i    (req),
`ifdef RAM_ARB_RR_EN
    .lg_i     (lg_q),
`endif
    .gnt_o    (gnt_raw),
    .winner_o (winner)
  );

  // Grants are held off combinationally while reset is asserted so nothing reaches the RAM.
  assign gnt       = rst_n ? gnt_raw : 2'b00;
  assign grant_any = |gnt;

  assign win_addr     = winner ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
  assign win_wdata    = winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  assign win_we       = we[winner];
  assign win_in_range = in_range(32'(win_addr), DEPTH);

  assign ram_addr = grant_any ? win_addr  : '0;
  assign ram_din  = grant_any ? win_wdata : '0;
  assign ram_we   = grant_any & win_we & win_in_range;

  always_comb begin
    rvalid_d = gnt & {2{~win_we}};
    rdata_d  = rdata_q;
    err_d    = grant_any & ~win_in_range;
    if (grant_any && !win_we) rdata_d = win_in_range ? ram_dout : '0;
`ifdef RAM_ARB_RR_EN
    lg_d = grant_any ? winner : lg_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef RAM_ARB_RR_EN
      lg_q     <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef RAM_ARB_RR_EN
      lg_q     <= lg_d;
`endif
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
